// File: rtl/text_buf_sched.sv
// Screen-buffer write scheduler: host single-cell writes interleaved with frame-synchronised
// clear / random-fill sweeps. Host wins a cycle only when host_ack is low, so sweeps always progress.
module text_buf_sched #(
  parameter int                    width      = 128,
  parameter int                    height     = 48,
  parameter int                    char_width = 8,
  parameter logic [char_width-1:0] blank_char = '0,
  parameter logic [15:0]           lfsr_seed  = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       refresh,
  input  logic                       fill_req,
  input  logic                       clear_req,
  input  logic                       host_req,
  input  logic [$clog2(width)-1:0]   host_x,
  input  logic [$clog2(height)-1:0]  host_y,
  input  logic [char_width-1:0]      host_c,
  output logic                       host_ack,
  output logic                       write_en,
  output logic [$clog2(width)-1:0]   x_w,
  output logic [$clog2(height)-1:0]  y_w,
  output logic [char_width-1:0]      c_w,
  output logic                       busy,
  output logic                       done
);
  localparam int XW = $clog2(width);
  localparam int YW = $clog2(height);
  localparam logic [XW-1:0] XMAX = XW'(width - 1);
  localparam logic [YW-1:0] YMAX = YW'(height - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SWEEP, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_fill, w_fill_nxt;
  logic [XW-1:0]         r_cx;
  logic [YW-1:0]         r_cy;
  logic                  r_last;
  logic [15:0]           r_lfsr;
  logic                  r_we, r_ack, r_busy, r_done;
  logic [XW-1:0]         r_xw;
  logic [YW-1:0]         r_yw;
  logic [char_width-1:0] r_cw;

  logic                  w_host_acc, w_sweep_wr, w_start, w_at_end;
  logic [15:0]           w_lfsr_nxt;
  logic [char_width-1:0] w_sweep_c;

  assign w_host_acc = host_req && !r_ack;
  assign w_at_end   = (r_cx == XMAX) && (r_cy == YMAX);
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_sweep_c  = r_fill ? r_lfsr[char_width-1:0] : blank_char;

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_sweep_wr  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_req || fill_req) begin
          w_state_nxt = ARMED;
          w_fill_nxt  = !clear_req;
        end
      end
      ARMED: begin
        if (clear_req || fill_req) w_fill_nxt = !clear_req;
        if (refresh) begin
          w_state_nxt = SWEEP;
          w_start     = 1'b1;
        end
      end
      SWEEP: begin
        // r_last: final cell already written; this cycle only retires the sweep
        if (r_last) begin
          w_state_nxt = DONE;
        end else if (clear_req) begin
          w_state_nxt = ARMED;
          w_fill_nxt  = 1'b0;
        end else if (!w_host_acc) begin
          w_sweep_wr = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill <= 1'b1;
      r_cx   <= '0;
      r_cy   <= '0;
      r_last <= 1'b0;
      r_lfsr <= lfsr_seed;
      r_we   <= 1'b0;
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_xw   <= '0;
      r_yw   <= '0;
      r_cw   <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      r_ack  <= w_host_acc;
      r_we   <= w_host_acc || w_sweep_wr;
      r_busy <= (w_state_nxt == ARMED) || (w_state_nxt == SWEEP);
      r_done <= (w_state_nxt == DONE);
      if (w_host_acc) begin
        r_xw <= host_x;
        r_yw <= host_y;
        r_cw <= host_c;
      end else if (w_sweep_wr) begin
        r_xw <= r_cx;
        r_yw <= r_cy;
        r_cw <= w_sweep_c;
      end
      if (w_start) begin
        r_cx   <= '0;
        r_cy   <= '0;
        r_last <= 1'b0;
      end else if (w_sweep_wr) begin
        if (r_fill) r_lfsr <= w_lfsr_nxt;
        if (w_at_end) r_last <= 1'b1;
        if (r_cx == XMAX) begin
          r_cx <= '0;
          r_cy <= r_cy + YW'(1);
        end else begin
          r_cx <= r_cx + XW'(1);
        end
      end
    end
  end

  assign host_ack = r_ack;
  assign write_en = r_we;
  assign x_w      = r_xw;
  assign y_w      = r_yw;
  assign c_w      = r_cw;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
